fetch_unit: RTL

Instruction fetch stage that consumes the address produced by `ProgramCounter` and returns the instruction stored there. It sits between `ProgramCounter` and the decode stage:
- tells the PC when an address has been taken, so the PC advances only then;
- runs a req/ack read against instruction memory;
- holds each fetched word in a valid/ready output register until decode accepts it.

A flush input discards in-flight and buffered instructions after a redirect.

---
 rtl/mini_pkg.sv | 16 +
 rtl/fetch_unit.sv | 95 +++++++++
 2 files changed

// File: rtl/mini_pkg.sv
// Shared types and defaults for the fetch stage.
package mini_pkg;

   localparam int unsigned DEFAULT_ADDR_W  = 32;
   localparam int unsigned DEFAULT_INSTR_W = 32;

   // Clears the byte-offset bits of a byte address.
   localparam logic [DEFAULT_ADDR_W-1:0] WORD_ALIGN = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: takes the PC, reads instruction memory over req/ack and
// holds the result in a valid/ready register for decode.
module fetch_unit
   import mini_pkg::*;
#(
   parameter int unsigned ADDR_W  = DEFAULT_ADDR_W,
   parameter int unsigned INSTR_W = DEFAULT_INSTR_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_W-1:0]  pc_in,
   output logic               pc_ready,
   input  logic               flush,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_ack,
   input  logic [INSTR_W-1:0] mem_rdata,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_misaligned
);

   // Upper address bits come through unchanged for any ADDR_W.
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(~WORD_ALIGN);

   fetch_state_t      state_q;
   fetch_state_t      state_d;
   logic [ADDR_W-1:0] addr_q;
   logic              free;
   logic              load;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state, PC handshake and output-register load strobe.
   always_comb begin
      state_d  = state_q;
      pc_ready = 1'b0;
      free     = !instr_valid || instr_ready;
      load     = 1'b0;
      case (state_q)
         IDLE: begin
            if (free && !flush) begin
               pc_ready = 1'b1;
               state_d  = REQ;
            end
         end
         REQ: begin
            if (mem_ack) begin
               load    = !flush;
               state_d = IDLE;
            end else if (flush) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (mem_ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (rst) pc_ready = 1'b0;
   end

   // Request address and the decode-facing output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q           <= '0;
         mem_addr         <= '0;
         mem_req          <= 1'b0;
         instr_valid      <= 1'b0;
         instr            <= '0;
         instr_pc         <= '0;
         instr_misaligned <= 1'b0;
      end else begin
         if (pc_ready) begin
            addr_q   <= pc_in;
            mem_addr <= pc_in & ALIGN_MASK;
         end
         mem_req <= (state_d != IDLE);
         if (flush)                           instr_valid <= 1'b0;
         else if (load)                       instr_valid <= 1'b1;
         else if (instr_valid && instr_ready) instr_valid <= 1'b0;
         if (load) begin
            instr            <= mem_rdata;
            instr_pc         <= addr_q;
            instr_misaligned <= |addr_q[1:0];
         end
      end
   end

endmodule
